// File: rtl/imem_loader.sv
// Instruction memory loader: streams little-endian program bytes into a 32-word memory,
// then releases the CPU. Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module imem_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [5:0]  load_len,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [5:0]  words_loaded
);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_mem [DEPTH];
  logic [5:0]  r_words;
  logic [5:0]  r_len;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_buf;

  logic w_accept;
  logic w_start;
  logic w_word_done;
  logic w_wr_en;
  logic w_last_word;
  logic w_unused_pc;

  assign rx_ready     = (r_state == StLoad) || (r_state == StCheck);
  assign w_accept     = rx_valid && rx_ready;
  assign w_start      = load_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_word_done  = w_accept && (r_state == StLoad) && (r_byte_idx == 2'd3);
  assign w_wr_en      = w_word_done && (r_words < 6'(DEPTH));
  assign w_last_word  = w_word_done && ((r_words + 6'd1) == r_len);

  assign instruction  = r_mem[pc[6:2]];
  assign w_unused_pc  = ^{pc[31:7], pc[1:0]};
  assign words_loaded = r_words;
  assign cpu_reset    = (r_state != StDone);
  assign load_done    = (r_state == StDone);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_total;
  logic       r_error;

  assign w_sum_total = r_sum + rx_data;
  assign load_error  = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= 8'd0;
      r_error <= 1'b0;
    end else if (w_start) begin
      r_sum   <= 8'd0;
      r_error <= 1'b0;
    end else if (w_accept && (r_state == StLoad)) begin
      r_sum <= w_sum_total;
    end else if (w_accept && (r_state == StCheck) && (w_sum_total != 8'd0)) begin
      r_error <= 1'b1;
    end
  end
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (load_start) w_state_next = StLoad;
      StLoad: begin
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = StCheck;
`else
          w_state_next = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (w_accept) w_state_next = (w_sum_total == 8'd0) ? StDone : StIdle;
      end
`endif
      StDone: if (load_start) w_state_next = StLoad;
      default: w_state_next = StIdle;
    endcase
  end

  // Only the first three bytes are buffered; the fourth goes straight into memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_words    <= 6'd0;
      r_len      <= 6'd0;
      r_byte_idx <= 2'd0;
      r_buf      <= 24'd0;
    end else if (w_start) begin
      r_words    <= 6'd0;
      r_len      <= (load_len == 6'd0) ? 6'd32 : load_len;
      r_byte_idx <= 2'd0;
      r_buf      <= 24'd0;
    end else if (w_accept && (r_state == StLoad)) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_buf[7:0]   <= rx_data;
        2'd1:    r_buf[15:8]  <= rx_data;
        2'd2:    r_buf[23:16] <= rx_data;
        default: r_buf        <= r_buf;
      endcase
      if (w_wr_en) r_words <= r_words + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_wr_en) begin
      r_mem[r_words[4:0]] <= {rx_data, r_buf};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a byte-count based reference model and per-cycle compare.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [5:0]  load_len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [5:0]  words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  imem_loader #(.DEPTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_len     (load_len),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 loading, 2 awaiting checksum, 3 done.
  logic [31:0] m_mem [32];
  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_len   = 0;
  logic [7:0]  m_sum   = 8'd0;
  logic        m_err   = 1'b0;
  logic [31:0] m_part  = 32'd0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      m_phase = 0; m_cnt = 0; m_sum = 8'd0; m_err = 1'b0; m_part = 32'd0;
      m_valid = 1'b1;
    end else if ((m_phase == 0 || m_phase == 3) && load_start) begin
      m_phase = 1;
      m_len   = (load_len == 6'd0) ? 32 : int'(load_len);
      m_cnt   = 0; m_sum = 8'd0; m_err = 1'b0; m_part = 32'd0;
    end else if (m_phase == 1 && rx_valid) begin
      m_part = m_part | (32'(rx_data) << (8 * (m_cnt % 4)));
      m_sum  = m_sum + rx_data;
      m_cnt  = m_cnt + 1;
      if (m_cnt % 4 == 0) begin
        m_mem[m_cnt / 4 - 1] = m_part;
        m_part = 32'd0;
      end
      if (m_cnt == 4 * m_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        m_phase = 2;
`else
        m_phase = 3;
`endif
      end
    end else if (m_phase == 2 && rx_valid) begin
      if (8'(m_sum + rx_data) == 8'd0) begin
        m_phase = 3;
      end else begin
        m_phase = 0;
        m_err   = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("rx_ready", 32'(rx_ready), 32'(m_phase == 1 || m_phase == 2));
      cmp("cpu_reset", 32'(cpu_reset), 32'(m_phase != 3));
      cmp("load_done", 32'(load_done), 32'(m_phase == 3));
      cmp("load_error", 32'(load_error), 32'(m_err));
      cmp("words_loaded", 32'(words_loaded), 32'(m_cnt / 4));
      cmp("instruction", instruction, m_mem[pc[6:2]]);
    end
  end

  logic [7:0] tb_sum;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_load(input logic [5:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    tb_sum     = 8'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tb_sum   = tb_sum + b;
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'd0 - tb_sum);
`endif
  endtask

  task automatic check_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    cmp(name, instruction, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; load_len = 6'd0;
    rx_data = 8'd0; rx_valid = 1'b0; pc = 32'd0;
    tick(); tick();
    cmp("reset_rx_ready", 32'(rx_ready), 32'd0);
    cmp("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    tick();

    // Single-word program
    start_load(6'd1);
    send_byte(8'hB3); send_byte(8'h03); send_byte(8'h53); send_byte(8'h00);
    finish_load();
    cmp("t1_load_done", 32'(load_done), 32'd1);
    cmp("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check_word("t1_pc0", 32'h0, 32'h005303B3);
    check_word("t1_pc3", 32'h3, 32'h005303B3);

    // Full 32-word load with rx_valid toggling
    start_load(6'd0);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'((i * 7 + 3) & 255));
      tick();
    end
    finish_load();
    cmp("t2_words", 32'(words_loaded), 32'd32);
    check_word("t2_pc7c", 32'h7C, 32'h7C756E67);
    check_word("t2_pc80", 32'h80, 32'h18110A03);
    check_word("t2_pchi", 32'hFFFF_FF80, 32'h18110A03);

    // Reset in the middle of a two-word load
    start_load(6'd2);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("t3_rx_ready", 32'(rx_ready), 32'd0);
    cmp("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    cmp("t3_words", 32'(words_loaded), 32'd0);
    for (int w = 0; w < 32; w++) check_word("t3_mem_zero", 32'(w * 4), 32'd0);
    tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accept, then reject
    start_load(6'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    cmp("t4_ok_done", 32'(load_done), 32'd1);
    start_load(6'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF5);
    cmp("t4_bad_error", 32'(load_error), 32'd1);
    cmp("t4_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    cmp("t4_bad_rx_ready", 32'(rx_ready), 32'd0);
    tick();
`endif

    // load_start while loading is ignored; reload from done keeps other words
    start_load(6'd2);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    load_start = 1'b1; load_len = 6'd5;
    tick();
    load_start = 1'b0;
    cmp("t5_words_hold", 32'(words_loaded), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    finish_load();
    cmp("t5_done", 32'(load_done), 32'd1);
    check_word("t5_w0", 32'h0, 32'hDDCCBBAA);
    start_load(6'd1);
    cmp("t5_reload_done_clr", 32'(load_done), 32'd0);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    finish_load();
    check_word("t5_reload_w0", 32'h0, 32'h00000013);
    check_word("t5_reload_w1", 32'h4, 32'h44332211);
    check_word("t5_reload_w2", 32'h8, 32'h00000000);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit instruction words; legal values are 32 only.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-005 SHALL have port load_len  input  6  word count sampled with load_start; 1..32 literal, 0 means 32.
REQ-006 SHALL have port rx_data  input  8  program byte stream.
REQ-007 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port pc  input  32  CPU fetch address.
REQ-010 SHALL have port instruction  output  32  fetched word.
REQ-011 SHALL have port cpu_reset  output  1  hold-in-reset for the CPU.
REQ-012 SHALL have port load_done  output  1  program loaded and CPU released.
REQ-013 SHALL have port load_error  output  1  checksum failure flag.
REQ-014 SHALL have port words_loaded  output  6  count of words written in the current load.

Function
REQ-015 SHALL implement the states IDLE, LOAD, CHECK and DONE; CHECK exists only per REQ-031.
REQ-016 SHALL transfer a byte only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 in LOAD/CHECK and 0 otherwise.
REQ-017 SHALL assemble bytes little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-018 SHALL write the assembled word to mem[words_loaded] on the edge accepting its 4th byte, and SHALL increment words_loaded on that edge.
REQ-019 SHALL drive instruction = mem[pc[6:2]] combinationally; pc[1:0] and pc[31:7] SHALL be ignored; a written word SHALL be visible the cycle after its write edge.
REQ-020 SHALL transition IDLE->LOAD on load_start=1, latch load_len, clear words_loaded, the byte index and the checksum.
REQ-021 SHALL also accept load_start in DONE; it SHALL clear load_done and load_error and enter LOAD (reload), leaving unwritten words holding their old contents.
REQ-022 SHALL ignore load_start in LOAD and CHECK.
REQ-023 SHALL leave LOAD on the edge writing the final word (words_loaded reaches latched length, 32 for load_len=0).
REQ-024 SHALL drive cpu_reset=1 in IDLE, LOAD, CHECK and 0 only in DONE; load_done SHALL be 1 exactly in DONE.
REQ-025 SHALL stall without data loss when rx_valid=0 mid-word; the partial word SHALL be held indefinitely.
REQ-026 SHALL not wrap the write address; words_loaded SHALL saturate at 32 and no write beyond index 31 SHALL occur.
REQ-027 SHALL hold load_error at 0 unless set per REQ-032.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, enter IDLE; clear all 32 memory words, words_loaded, byte index and checksum; drive rx_ready=0, cpu_reset=1, load_done=0, load_error=0.
REQ-029 SHALL treat reset during LOAD or CHECK identically, discarding any partial word.
REQ-030 SHALL give reset priority over load_start on the same edge.

Configuration
REQ-031 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, go LOAD->CHECK after the final word, accept one checksum byte in CHECK, and keep an 8-bit sum of all data bytes modulo 256.
REQ-032 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, enter DONE if (sum + checksum byte) mod 256 == 0, else set load_error=1 and enter IDLE (cpu_reset stays 1; memory retains written words).
REQ-033 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit CHECK, go LOAD->DONE directly, and tie load_error to 0.

Verification
REQ-034 SHALL cover: reset, load_start with load_len=1, bytes B3 03 53 00 -> mem[0]=0x005303B3, instruction=0x005303B3 at pc=0x0 and pc=0x3, cpu_reset=0 and load_done=1 the cycle after the last accepted byte (no checksum).
REQ-035 SHALL cover: load_len=0, 128 bytes with rx_valid toggled every other cycle -> words_loaded=32, pc=0x7C returns word 31, pc=0x80 returns word 0.
REQ-036 SHALL cover: reset asserted after 6 bytes of a 2-word load -> IDLE, all memory 0, rx_ready=0, cpu_reset=1, words_loaded=0.
REQ-037 SHALL cover: checksum build, bytes 01 02 03 04 then checksum F6 -> DONE; same bytes with checksum F5 -> load_error=1, IDLE, cpu_reset=1.
REQ-038 SHALL cover: load_start pulsed mid-LOAD -> ignored, word count unchanged; load_start in DONE with load_len=1 and bytes 13 00 00 00 -> mem[0]=0x00000013, mem[1..31] unchanged.
